instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst_n; rst_n is active-high regardless of its suffix.
REQ-002 Parameter n, default 32, SHALL set the instruction and address width.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of prefetch buffer entries (power of two, 2..16).
REQ-004 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-005 The ports SHALL be, one per entry (name  direction  width  meaning):
  clk  in  1  clock
  rst_n  in  1  synchronous reset, active-high
  imem_req  out  1  fetch request to instruction memory
  imem_addr  out  n  word-aligned fetch address, valid while imem_req=1
  imem_gnt  in  1  memory accepts request this cycle
  imem_rvalid  in  1  read data valid
  imem_rdata  in  n  fetched instruction word
  redirect  in  1  branch/jump taken; restart fetch
  redirect_pc  in  n  new fetch address
  instr_valid  out  1  instr_out/instr_pc hold a valid entry
  instr_out  out  n  instruction presented to the decode/execute stage
  instr_pc  out  n  address of instr_out
  instr_ready  in  1  consumer accepts the entry this cycle
  buf_count  out  log2(DEPTH)+1  occupied buffer entries

Function
REQ-006 At most one memory request SHALL be outstanding; a request is outstanding from the imem_gnt cycle until its imem_rvalid.
REQ-007 imem_req SHALL be asserted only when no request is outstanding, the FSM is in RUN, redirect=0, and buf_count + 1 <= DEPTH.
REQ-008 imem_req and imem_addr SHALL remain stable until imem_gnt; on imem_gnt the fetch PC SHALL advance by 4, wrapping modulo 2^n.
REQ-009 In RUN, imem_rvalid SHALL push {fetched PC, imem_rdata} into the buffer; instr_valid SHALL rise in the cycle after the push.
REQ-010 An entry SHALL be popped when instr_valid & instr_ready; push and pop in the same cycle SHALL leave buf_count unchanged.
REQ-011 Because of the space reservation in REQ-007, a push SHALL never occur when full; instr_valid=0 SHALL mean empty, and instr_ready while empty SHALL be ignored.
REQ-012 FSM states SHALL be RUN (normal) and DROP (discarding one stale response).
REQ-013 On redirect, the block SHALL flush the buffer (buf_count=0, instr_valid=0 the next cycle) and load the fetch PC with {redirect_pc[n-1:2], 2'b00}. If a request is outstanding, or imem_gnt occurs in the same cycle, the FSM SHALL move to DROP.
REQ-014 In DROP, the next imem_rvalid SHALL be discarded and the FSM SHALL return to RUN; imem_req SHALL stay low while in DROP.
REQ-015 Redirect SHALL take priority over a same-cycle push and pop; the popped entry is still considered consumed.
REQ-016 A redirect while in DROP SHALL reload the fetch PC and remain in DROP.
REQ-017 instr_out and instr_pc SHALL be driven from the buffer head register, with no combinational path from imem_rdata.

Reset
REQ-018 On rst_n=1 at a clk edge: fetch PC = RESET_PC, FSM = RUN, outstanding = 0, buf_count = 0, instr_valid = 0, imem_req = 0. instr_out and instr_pc SHALL be 0.
REQ-019 Reset asserted mid-operation SHALL abandon any outstanding request; the first imem_rvalid after reset without a post-reset grant SHALL be ignored.
REQ-020 imem_req SHALL first assert in the first cycle after reset deasserts.

Structure
REQ-021 A shared package SHALL hold the RESET_PC default, the DEPTH default, and the FSM state enumeration.
REQ-022 The buffer SHALL be a sub-module, fetch_fifo, parameterised by width (2n) and DEPTH, with push, pop, flush, count and head outputs.

Verification
REQ-023 Reset release, memory with gnt=1 and one-cycle rvalid, instr_ready=1 -> instr_pc sequence 0, 4, 8, 12, instr_valid continuous after the first.
REQ-024 instr_ready=0 for 20 cycles -> buf_count saturates at 4, imem_req=0, no push lost; ready=1 -> entries 0..12 drain in order.
REQ-025 Redirect to 32'h0000_0103 while a request is outstanding -> stale rvalid dropped, next imem_addr = 32'h0000_0100, first instr_pc = 32'h100.
REQ-026 Redirect_pc = 32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000 (wrap).
REQ-027 Redirect coinciding with push and pop -> buf_count = 0 next cycle, instr_valid = 0.
REQ-028 Reset pulse with one request outstanding -> following rvalid ignored, first post-reset imem_addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared defaults and FSM state encoding for the instruction fetch unit
package instr_fetch_unit_pkg;
    localparam int          IFU_DEPTH    = 4;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } ifu_state_e;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry prefetch queue; the head is read straight from the storage registers
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       head_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;
    always_comb begin
        do_push = push_i && !flush_i && (cnt_q < (AW+1)'(DEPTH));
        do_pop  = pop_i && (cnt_q != '0);
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        cnt_d   = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end
    assign count_o = cnt_q;
    assign valid_o = cnt_q != '0;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction prefetcher with redirect flush and stale-response drop
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int           n        = 32,
    parameter int           DEPTH    = IFU_DEPTH,
    parameter logic [n-1:0] RESET_PC = n'(IFU_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [n-1:0]           imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [n-1:0]           imem_rdata,
    input  logic                   redirect,
    input  logic [n-1:0]           redirect_pc,
    output logic                   instr_valid,
    output logic [n-1:0]           instr_out,
    output logic [n-1:0]           instr_pc,
    input  logic                   instr_ready,
    output logic [$clog2(DEPTH):0] buf_count
);
    localparam logic [n-1:0] ALIGN = ~n'(3);
    ifu_state_e     state_q, state_d;
    logic [n-1:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic           out_q, out_d;
    logic           room, fire, done, push, pop;
    logic [2*n-1:0] head;
    always_comb begin
        // in-flight response counts against free space so a push can never hit a full buffer
        room     = (int'(buf_count) + int'(out_q)) < DEPTH;
        imem_req = !rst_n && (state_q == RUN) && !redirect && (!out_q || imem_rvalid) && room;
        fire     = imem_req && imem_gnt;
        done     = out_q && imem_rvalid;
        push     = done && (state_q == RUN) && !redirect;
        pop      = instr_valid && instr_ready;
        out_d    = fire || (out_q && !done);
        pc_d     = redirect ? (redirect_pc & ALIGN) : fire ? pc_q + n'(4) : pc_q;
        req_pc_d = fire ? pc_q : req_pc_q;
        // DROP only while a stale response is still owed; a same-cycle rvalid already settled it
        state_d  = redirect ? (out_d ? DROP : RUN) : ((state_q == DROP) && done) ? RUN : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
        end
    end
    fetch_fifo #(
        .WIDTH(2*n),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst_n),
        .push_i (push),
        .data_i ({req_pc_q, imem_rdata}),
        .pop_i  (pop),
        .flush_i(redirect),
        .count_o(buf_count),
        .valid_o(instr_valid),
        .head_o (head)
    );
    assign imem_addr = pc_q;
    assign instr_pc  = head[2*n-1:n];
    assign instr_out = head[n-1:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with a variable-latency memory model and a redirect vector table
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    logic        clk, rst_n, imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_out, instr_pc;
    logic [2:0]  buf_count;

    instr_fetch_unit #(.n(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .buf_count(buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rpc;
        int          lat;
        logic [31:0] a1;
        logic [31:0] a2;
    } vec_t;
    vec_t        vecs [5];
    int          tests, fails;
    logic [63:0] exp_q [$];
    logic [31:0] fire_log [$];
    logic [31:0] pop_log [$];
    logic        rst_v, redir_v, rdy_v, mem_busy, mem_stale, seen_valid, last_pp;
    logic [31:0] rpc_v, mem_addr, exp_pc;
    int          lat, mem_cnt, gaps;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idx(input string nm, input logic [31:0] q [$], input int i, input logic [31:0] e);
        if (i < q.size()) chk(nm, {32'h0, q[i]}, {32'h0, e});
        else chk(nm, {64{1'bx}}, {32'h0, e});
    endtask

    // one clock: drive at negedge, settle, check and update the model, then advance to the next negedge
    task automatic cycle();
        logic [63:0] e;
        rst_n       = rst_v;
        redirect    = redir_v;
        redirect_pc = rpc_v;
        instr_ready = rdy_v;
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~mem_addr;
                mem_busy    = 1'b0;
            end else mem_cnt--;
        end
        imem_gnt = !mem_busy;
        #1;
        if (rst_v) begin
            chk("req_in_reset", {63'h0, imem_req}, 64'h0);
            exp_q.delete();
            exp_pc = RST_PC;
            if (imem_rvalid) mem_stale = 1'b0;
            if (mem_busy) mem_stale = 1'b1;
        end else begin
            chk("buf_count", {61'h0, buf_count}, 64'(exp_q.size()));
            chk("instr_valid", {63'h0, instr_valid}, {63'h0, exp_q.size() != 0});
            if (instr_valid) seen_valid = 1'b1;
            else if (seen_valid) gaps++;
            last_pp = imem_rvalid && instr_valid && instr_ready;
            if (instr_valid && instr_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pop_pc", {32'h0, instr_pc}, {32'h0, e[63:32]});
                chk("pop_instr", {32'h0, instr_out}, {32'h0, e[31:0]});
                pop_log.push_back(instr_pc);
            end
            if (imem_rvalid) begin
                if (!mem_stale && !redir_v) exp_q.push_back({mem_addr, ~mem_addr});
                mem_stale = 1'b0;
            end
            if (redir_v) begin
                chk("req_during_redirect", {63'h0, imem_req}, 64'h0);
                exp_q.delete();
                exp_pc = {rpc_v[31:2], 2'b00};
                if (mem_busy) mem_stale = 1'b1;
            end
            if (imem_req && imem_gnt) begin
                chk("imem_addr", {32'h0, imem_addr}, {32'h0, exp_pc});
                fire_log.push_back(imem_addr);
                exp_pc   = exp_pc + 32'd4;
                mem_busy = 1'b1;
                mem_cnt  = lat - 1;
                mem_addr = imem_addr;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        run(2);
        rst_v = 1'b0;
        fire_log.delete();
        pop_log.delete();
    endtask

    task automatic wait_outstanding();
        for (int i = 0; i < 12 && !(mem_busy && mem_cnt > 0); i++) cycle();
        chk("outstanding_reached", {63'h0, mem_busy && mem_cnt > 0}, 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int mark, pmark;
        vecs[0] = '{32'h0000_0103, 3, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_0002, 2, 32'h0000_0000, 32'h0000_0004};
        vecs[3] = '{32'h8000_0057, 1, 32'h8000_0054, 32'h8000_0058};
        vecs[4] = '{32'h0000_1000, 4, 32'h0000_1000, 32'h0000_1004};
        tests = 0; fails = 0; gaps = 0; seen_valid = 1'b0; last_pp = 1'b0;
        rst_v = 1'b1; redir_v = 1'b0; rpc_v = '0; rdy_v = 1'b1; lat = 1;
        mem_busy = 1'b0; mem_stale = 1'b0; mem_cnt = 0; mem_addr = '0; exp_pc = RST_PC;
        rst_n = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);
        do_reset();
        chk("rst_instr_out", {32'h0, instr_out}, 64'h0);
        chk("rst_instr_pc", {32'h0, instr_pc}, 64'h0);
        chk("rst_buf_count", {61'h0, buf_count}, 64'h0);
        chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_imem_req", {63'h0, imem_req}, 64'h0);
        // streaming fetch, one-cycle memory, always-ready consumer
        cycle();
        chk("first_req_after_reset", 64'(fire_log.size()), 64'h1);
        gaps = 0; seen_valid = 1'b0;
        run(12);
        chk("valid_gaps", 64'(gaps), 64'h0);
        for (int i = 0; i < 4; i++) chk_idx("stream_pc", pop_log, i, 32'(4 * i));
        // stalled consumer fills the buffer, then drains in order
        do_reset();
        rdy_v = 1'b0;
        run(20);
        chk("full_buf_count", {61'h0, buf_count}, 64'h4);
        chk("full_imem_req", {63'h0, imem_req}, 64'h0);
        chk("full_fetches", 64'(fire_log.size()), 64'h4);
        rdy_v = 1'b1;
        run(8);
        for (int i = 0; i < 4; i++) chk_idx("drain_pc", pop_log, i, 32'(4 * i));
        // redirect vectors: target alignment, wrap, drop of an outstanding response
        foreach (vecs[v]) begin
            lat = vecs[v].lat;
            run(6);
            if (vecs[v].lat > 1) wait_outstanding();
            redir_v = 1'b1;
            rpc_v   = vecs[v].rpc;
            cycle();
            redir_v = 1'b0;
            if (vecs[v].lat == 1) chk("redirect_push_pop", {63'h0, last_pp}, 64'h1);
            chk("flush_count", {61'h0, buf_count}, 64'h0);
            chk("flush_valid", {63'h0, instr_valid}, 64'h0);
            mark  = fire_log.size();
            pmark = pop_log.size();
            for (int i = 0; i < 30 && (fire_log.size() < mark + 2 || pop_log.size() <= pmark); i++) cycle();
            chk_idx("redir_addr1", fire_log, mark, vecs[v].a1);
            chk_idx("redir_addr2", fire_log, mark + 1, vecs[v].a2);
            chk_idx("redir_first_pc", pop_log, pmark, vecs[v].a1);
        end
        // back-to-back redirects while a response is still owed
        lat = 5;
        run(3);
        wait_outstanding();
        redir_v = 1'b1; rpc_v = 32'h0000_0200;
        cycle();
        rpc_v = 32'h0000_0301;
        cycle();
        redir_v = 1'b0;
        mark  = fire_log.size();
        pmark = pop_log.size();
        for (int i = 0; i < 30 && (fire_log.size() <= mark || pop_log.size() <= pmark); i++) cycle();
        chk_idx("double_redir_addr", fire_log, mark, 32'h0000_0300);
        chk_idx("double_redir_pc", pop_log, pmark, 32'h0000_0300);
        // reset pulse with a request outstanding; its late response must be ignored
        lat = 4;
        run(2);
        wait_outstanding();
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        fire_log.delete();
        pop_log.delete();
        for (int i = 0; i < 30 && (fire_log.size() == 0 || pop_log.size() == 0); i++) cycle();
        chk_idx("post_reset_addr", fire_log, 0, RST_PC);
        chk_idx("post_reset_pc", pop_log, 0, RST_PC);
        run(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
